// File: rtl/ex_stage_mc.sv
// ex_stage_mc: execute stage of the 5-stage pipelined MIPS core.
//
// Purpose:
//   Operand forwarding, single-cycle ALU, destination-register selection,
//   an iterative multiply/divide unit with HI/LO registers (one step per
//   cycle, WIDTH cycles per operation) and a registered EX/MEM boundary.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid, flush   ID/EX entry valid; kill current instruction / mul-div
//   fwd_a, fwd_b      one-hot operand sources (001 ID/EX, 010 EX/MEM, 100 MEM/WB)
//   id_ex_a, id_ex_b  register-file operands
//   ex_mem_fwd        forwarded EX/MEM result
//   mem_wb_fwd        forwarded MEM/WB result
//   imm, shamt        immediate and shift amount
//   alu_op, alu_src   operation code; 1 = operand B is imm
//   reg_dst, rt, rd   destination select and register fields
//   ex_stall          upstream hold while the mul/div unit is busy
//   out_*             registered EX/MEM outputs
//
// Optional feature: define EX_OVF_TRAP_EN to detect signed overflow on
// ADD/SUB (out_ovf = 1, destination forced to register 0). Without it
// out_ovf is tied to 0.

module ex_stage_mc #(
    parameter int WIDTH   = 32,
    parameter int RADDR   = 5,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               flush,
    input  logic [2:0]         fwd_a,
    input  logic [2:0]         fwd_b,
    input  logic [WIDTH-1:0]   id_ex_a,
    input  logic [WIDTH-1:0]   id_ex_b,
    input  logic [WIDTH-1:0]   ex_mem_fwd,
    input  logic [WIDTH-1:0]   mem_wb_fwd,
    input  logic [WIDTH-1:0]   imm,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [4:0]         alu_op,
    input  logic               alu_src,
    input  logic               reg_dst,
    input  logic [RADDR-1:0]   rt,
    input  logic [RADDR-1:0]   rd,
    output logic               ex_stall,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_zero,
    output logic [WIDTH-1:0]   out_store_data,
    output logic [RADDR-1:0]   out_reg_dest,
    output logic               out_ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]   op_a, op_b_fwd, op_b, alu_result;
    logic [WIDTH-1:0]   hi, lo;
    logic [CNT_W-1:0]   counter;
    logic               md_mul, md_signed;
    logic [WIDTH-1:0]   md_a, md_b, md_mag_b;
    logic [2*WIDTH-1:0] md_acc, step_next, prod_final;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]   hi_final, lo_final, mag_a, mag_b;
    logic               is_muldiv, start_signed, start_mul;
    logic               accept_single, start_md, md_neg_q;

    // Anything that is not exactly one-hot falls back to the register file.
    function automatic logic [WIDTH-1:0] fwd_select(input logic [2:0] sel,
                                                    input logic [WIDTH-1:0] reg_val,
                                                    input logic [WIDTH-1:0] ex_val,
                                                    input logic [WIDTH-1:0] wb_val);
        case (sel)
            3'b010:  return ex_val;
            3'b100:  return wb_val;
            default: return reg_val;
        endcase
    endfunction

    assign op_a     = fwd_select(fwd_a, id_ex_a, ex_mem_fwd, mem_wb_fwd);
    assign op_b_fwd = fwd_select(fwd_b, id_ex_b, ex_mem_fwd, mem_wb_fwd);
    assign op_b     = alu_src ? imm : op_b_fwd;

    assign is_muldiv     = (alu_op >= 5'd17) && (alu_op <= 5'd20);
    assign start_mul     = (alu_op == 5'd17) || (alu_op == 5'd18);
    assign start_signed  = (alu_op == 5'd17) || (alu_op == 5'd19);
    assign accept_single = in_valid && !flush && (state == IDLE) && !is_muldiv;
    assign start_md      = in_valid && !flush && (state == IDLE) && is_muldiv;
    assign ex_stall      = (state == BUSY);

    always_comb begin
        alu_result = '0;
        case (alu_op)
            5'd0:  alu_result = op_a + op_b;
            5'd1:  alu_result = op_a - op_b;
            5'd2:  alu_result = op_a & op_b;
            5'd3:  alu_result = op_a | op_b;
            5'd4:  alu_result = op_a ^ op_b;
            5'd5:  alu_result = ~(op_a | op_b);
            5'd6:  alu_result = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            5'd7:  alu_result = {{(WIDTH-1){1'b0}}, op_a < op_b};
            5'd8:  alu_result = op_b << shamt;
            5'd9:  alu_result = op_b >> shamt;
            5'd10: alu_result = $signed(op_b) >>> shamt;
            5'd11: alu_result = op_b << op_a[SHAMT_W-1:0];
            5'd12: alu_result = op_b >> op_a[SHAMT_W-1:0];
            5'd13: alu_result = $signed(op_b) >>> op_a[SHAMT_W-1:0];
            5'd14: alu_result = op_b << (WIDTH / 2);
            5'd15: alu_result = hi;
            5'd16: alu_result = lo;
            default: alu_result = '0;
        endcase
    end

    // The iterative unit works on magnitudes; signs are reapplied on the
    // final step. md_acc holds {upper product, multiplier} for multiply and
    // {remainder, dividend/quotient} for division.
    always_comb begin
        mag_a     = (start_signed && op_a[WIDTH-1]) ? -op_a : op_a;
        mag_b     = (start_signed && op_b[WIDTH-1]) ? -op_b : op_b;
        mul_sum   = {1'b0, md_acc[2*WIDTH-1:WIDTH]}
                    + (md_acc[0] ? {1'b0, md_mag_b} : {(WIDTH+1){1'b0}});
        div_shift = {md_acc[2*WIDTH-1:WIDTH], md_acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, md_mag_b};
        if (md_mul)
            step_next = {mul_sum, md_acc[WIDTH-1:1]};
        else if (div_diff[WIDTH])
            step_next = {div_shift[WIDTH-1:0], md_acc[WIDTH-2:0], 1'b0};
        else
            step_next = {div_diff[WIDTH-1:0], md_acc[WIDTH-2:0], 1'b1};
        md_neg_q   = md_signed && (md_a[WIDTH-1] ^ md_b[WIDTH-1]);
        prod_final = md_neg_q ? -step_next : step_next;
        if (md_mul) begin
            hi_final = prod_final[2*WIDTH-1:WIDTH];
            lo_final = prod_final[WIDTH-1:0];
        end else if (md_b == '0) begin
            hi_final = md_a;
            lo_final = '1;
        end else begin
            lo_final = md_neg_q ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
            hi_final = (md_signed && md_a[WIDTH-1]) ? -step_next[2*WIDTH-1:WIDTH]
                                                    : step_next[2*WIDTH-1:WIDTH];
        end
    end

    // Mul/div controller state register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Leave BUSY on flush (abort) or once the last step is taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_md) state_next = BUSY;
            BUSY:    if (flush || counter == CNT_W'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Mul/div datapath: latch operands at start, step once per BUSY cycle,
    // commit HI/LO on the final step. A flush discards the partial result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter   <= '0;
            hi        <= '0;
            lo        <= '0;
            md_mul    <= 1'b0;
            md_signed <= 1'b0;
            md_a      <= '0;
            md_b      <= '0;
            md_mag_b  <= '0;
            md_acc    <= '0;
        end else if (state == IDLE) begin
            if (start_md) begin
                counter   <= CNT_W'(WIDTH);
                md_mul    <= start_mul;
                md_signed <= start_signed;
                md_a      <= op_a;
                md_b      <= op_b;
                md_mag_b  <= mag_b;
                md_acc    <= {{WIDTH{1'b0}}, mag_a};
            end
        end else if (flush) begin
            counter <= '0;
        end else begin
            md_acc  <= step_next;
            counter <= counter - CNT_W'(1);
            if (counter == CNT_W'(1)) begin
                hi <= hi_final;
                lo <= lo_final;
            end
        end
    end

`ifdef EX_OVF_TRAP_EN
    logic ovf_detect;

    // Same-sign operands (after negating B for SUB) giving a different-sign
    // result means the signed result wrapped.
    always_comb begin
        ovf_detect = 1'b0;
        if (alu_op == 5'd0)
            ovf_detect = (op_a[WIDTH-1] == op_b[WIDTH-1])
                         && (alu_result[WIDTH-1] != op_a[WIDTH-1]);
        else if (alu_op == 5'd1)
            ovf_detect = (op_a[WIDTH-1] != op_b[WIDTH-1])
                         && (alu_result[WIDTH-1] != op_a[WIDTH-1]);
    end
`endif

    // EX/MEM boundary: bubbles clear out_valid but hold the data fields.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_zero       <= 1'b0;
            out_store_data <= '0;
            out_reg_dest   <= '0;
`ifdef EX_OVF_TRAP_EN
            out_ovf        <= 1'b0;
`endif
        end else begin
            out_valid <= accept_single;
            if (accept_single) begin
                out_result     <= alu_result;
                out_zero       <= (alu_result == '0);
                out_store_data <= op_b_fwd;
`ifdef EX_OVF_TRAP_EN
                out_ovf        <= ovf_detect;
                out_reg_dest   <= ovf_detect ? '0 : (reg_dst ? rd : rt);
`else
                out_reg_dest   <= reg_dst ? rd : rt;
`endif
            end
        end
    end

`ifndef EX_OVF_TRAP_EN
    assign out_ovf = 1'b0;
`endif

endmodule

// File: doc/ex_stage_mc.md
Name: ex_stage_mc

Overview:
- Next-generation execute stage for the 5-stage pipelined MIPS core.
- Provides parametrised operand forwarding, a full ALU and destination-register selection.
- Adds an iterative multi-cycle multiply/divide unit with HI/LO registers, a stall handshake to the upstream stages, and a registered EX/MEM output boundary.

Parameters:
- WIDTH, 32, datapath width in bits (even, at least 8).
- RADDR, 5, register-address width.
- SHAMT_W, 5, shift-amount width; log2(WIDTH).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  ID/EX holds a valid instruction.
- flush  in  1  kill the current instruction and any mul/div in flight.
- fwd_a  in  3  one-hot operand-A source: 001 = ID/EX, 010 = EX/MEM, 100 = MEM/WB.
- fwd_b  in  3  same encoding, for operand B.
- id_ex_a  in  WIDTH  register-file value for rs.
- id_ex_b  in  WIDTH  register-file value for rt.
- ex_mem_fwd  in  WIDTH  forwarded EX/MEM result.
- mem_wb_fwd  in  WIDTH  forwarded MEM/WB result.
- imm  in  WIDTH  sign/zero-extended immediate.
- shamt  in  SHAMT_W  shift amount.
- alu_op  in  5  operation code (see Behaviour).
- alu_src  in  1  1 = operand B is imm.
- reg_dst  in  1  1 = destination is rd, 0 = rt.
- rt  in  RADDR  rt field.
- rd  in  RADDR  rd field.
- ex_stall  out  1  upstream must hold; high while mul/div busy.
- out_valid  out  1  registered; EX/MEM entry valid.
- out_result  out  WIDTH  registered ALU result.
- out_zero  out  1  registered; out_result == 0.
- out_store_data  out  WIDTH  registered forwarded operand B (before the alu_src mux).
- out_reg_dest  out  RADDR  registered destination register.
- out_ovf  out  1  registered signed overflow (EX_OVF_TRAP_EN only; otherwise tied to 0).

Behaviour:
- Reset (rst_n == 0 at a clk edge):
  - all out_* = 0 and ex_stall = 0;
  - HI = LO = 0, FSM = IDLE, counter = 0.
- Forwarding (combinational):
  - opA: 001 → id_ex_a, 010 → ex_mem_fwd, 100 → mem_wb_fwd.
  - Any other fwd_a pattern (000 or multi-hot) selects id_ex_a.
  - fwd_b selects opB_fwd by the same rules.
  - opB = alu_src ? imm : opB_fwd.
- alu_op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU;
  - 8 SLL, 9 SRL, 10 SRA (shift opB by shamt), 11 SLLV, 12 SRLV, 13 SRAV (shift by opA[SHAMT_W-1:0]);
  - 14 LUI (opB << WIDTH/2), 15 MFHI, 16 MFLO;
  - 17 MULT, 18 MULTU, 19 DIV, 20 DIVU;
  - 21–31 produce 0.
  - SLT/SLTU results are zero-extended 0/1.
  - Arithmetic wraps modulo 2^WIDTH.
- Single-cycle ops: if in_valid and not busy and not flush, at the next edge:
  - out_valid = 1, out_result = ALU result, out_zero = (result == 0);
  - out_reg_dest = reg_dst ? rd : rt, out_store_data = opB_fwd.
  - Latency: 1 cycle.
- Bubbles: if in_valid = 0, or flush = 1, the next edge gives out_valid = 0; the other out_* hold their previous values.
- Mul/div FSM, states IDLE and BUSY:
  - IDLE → BUSY on in_valid & mul/div op & !flush, at edge T.
  - At T the unit latches the operands and the signedness, counter = WIDTH, and out_valid = 0 (the mul/div writes no GPR).
  - BUSY: one shift-add (multiply) or restoring-division step per cycle; counter decrements each cycle.
  - At the edge where counter reaches 0 (edge T+WIDTH), HI/LO are written and the FSM returns to IDLE.
  - MULT/MULTU: {HI, LO} = 2·WIDTH-bit product.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero: LO = all ones, HI = dividend; the operation still takes WIDTH cycles.
  - Signed most-negative / −1: LO = most-negative, HI = 0.
  - ex_stall = (state == BUSY), registered; high for exactly WIDTH cycles, from T+1 through T+WIDTH.
  - in_valid is ignored while BUSY; out_valid = 0 while BUSY.
- First instruction after a mul/div is accepted at T+WIDTH+1 and sees the updated HI/LO (MFHI/MFLO need no extra stall).
- flush while BUSY:
  - aborts the operation and returns to IDLE next edge;
  - HI/LO unchanged, ex_stall drops next cycle.
- flush and in_valid together: flush wins.
- rst_n low mid-BUSY: the reset values above apply at that edge.

Optional Feature:
- Macro: EX_OVF_TRAP_EN.
- Defined:
  - ADD and SUB (and only these) detect signed overflow.
  - On overflow: out_ovf = 1, out_valid = 1, out_reg_dest = 0 (write suppressed), out_result = wrapped sum.
  - Otherwise out_ovf = 0.
- Undefined:
  - out_ovf is tied to 0 and no overflow logic is synthesised.
  - Overflowing ADD/SUB write normally.

Test Plan (WIDTH = 32):
- Forwarding: fwd_a = 010, ex_mem_fwd = 7, fwd_b = 100, mem_wb_fwd = 5, ADD, reg_dst = 1, rd = 9 → next cycle out_result = 12, out_reg_dest = 9, out_valid = 1. Repeat with fwd_a = 011 → opA = id_ex_a.
- SLT vs SLTU: opA = 0xFFFFFFFF, opB = 1 → SLT gives 1, SLTU gives 0. SRA of 0x80000000 by shamt 4 → 0xF8000000.
- MULT: opA = −3, opB = 7, then MFLO and MFHI → ex_stall high for exactly 32 cycles, LO = 0xFFFFFFEB, HI = 0xFFFFFFFF. Next instruction accepted at T+33.
- DIV: −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 5 / 0 → LO = 0xFFFFFFFF, HI = 5.
- Flush at cycle T+10 of a MULTU → ex_stall low from T+11 and HI/LO keep their prior values. Reset at T+5 → all outputs 0 next cycle.
- EX_OVF_TRAP_EN: 0x7FFFFFFF + 1 → out_ovf = 1, out_reg_dest = 0, out_result = 0x80000000. Without the macro → out_ovf = 0 and the normal destination is written.
